// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed-select or round-robin arbitration and one output
// register stage. Define STREAM_MUX_PKT_LOCK_EN to keep a round-robin grant for a whole packet.
module stream_mux_rr #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_last,
    output logic [N_CH-1:0]          in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic              lock_q, lock_d;
    logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
`endif

    logic              load;
    logic              grant_any;
    logic              xfer;
    logic [SEL_W-1:0]  grant_idx;
    logic [SEL_W-1:0]  ptr_next;
    int unsigned       scan;

    // Grant: one winner encoded as grant_idx, qualified by grant_any.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan      = 0;
        if (!mode) begin
            if (32'(sel) < N_CH) begin
                grant_any = in_valid[sel];
                grant_idx = sel;
            end
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                scan = 32'(rr_ptr_q) + k;
                if (scan >= N_CH) begin
                    scan = scan - N_CH;
                end
                if (!grant_any && in_valid[SEL_W'(scan)]) begin
                    grant_any = 1'b1;
                    grant_idx = SEL_W'(scan);
                end
            end
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        // A locked packet owns the mux even while its producer stalls.
        if (lock_q) begin
            grant_any = in_valid[lock_ch_q];
            grant_idx = lock_ch_q;
        end
`endif
    end

    always_comb begin
        load = !out_valid_q || out_ready;
        xfer = load && grant_any && rst_n;
        for (int unsigned i = 0; i < N_CH; i++) begin
            in_ready[i] = xfer && (grant_idx == SEL_W'(i));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        ptr_next    = (32'(grant_idx) == N_CH - 1) ? '0 : grant_idx + 1'b1;
        if (load) begin
            out_valid_d = grant_any;
        end
        if (xfer) begin
            out_data_d = in_data[grant_idx*DATA_W +: DATA_W];
            out_last_d = in_last[grant_idx];
            out_ch_d   = grant_idx;
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (xfer && (lock_q || mode)) begin
            if (in_last[grant_idx]) begin
                lock_d   = 1'b0;
                rr_ptr_d = ptr_next;
            end else begin
                lock_d    = 1'b1;
                lock_ch_d = grant_idx;
            end
        end
`else
        if (xfer && mode) begin
            rr_ptr_d = ptr_next;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: vector table for select/backpressure, scoreboard for streaming sequences.
`timescale 1ns/1ps
module tb_stream_mux_rr;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam logic [31:0] D0 = 32'h44_A5_22_11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    in_valid, in_last, in_ready;
    logic [N*DW-1:0] in_data;
    logic            mode, out_ready;
    logic [1:0]      sel, out_ch;
    logic            out_valid, out_last;
    logic [DW-1:0]   out_data;

    logic [4:0]  v5, l5, r5;
    logic [39:0] d5;
    logic [2:0]  sel5, och5;
    logic        ov5, ol5;
    logic [7:0]  od5;

    stream_mux_rr #(.N_CH(N), .DATA_W(DW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .out_ch(out_ch), .out_ready(out_ready)
    );

    stream_mux_rr #(.N_CH(5), .DATA_W(8)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_data(d5), .in_last(l5),
        .in_ready(r5), .mode(mode), .sel(sel5), .out_valid(ov5),
        .out_data(od5), .out_last(ol5), .out_ch(och5), .out_ready(out_ready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*DW-1:0] data;
        logic [N-1:0]    last;
        logic            mode;
        logic [1:0]      sel;
        logic            ordy;
        logic [N-1:0]    exp_rdy;
        logic            exp_ov;
        logic [DW-1:0]   exp_od;
        logic [1:0]      exp_ch;
        logic            exp_ol;
    } vec_t;

    typedef struct {
        logic [1:0]    ch;
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    vec_t vecs[7];
    exp_t q[$];

    function automatic logic [DW-1:0] byte_of(input logic [31:0] w, input int ch);
        return w[ch*8 +: 8];
    endfunction

    task automatic pop_check(input string name);
        exp_t e;
        chk({name, "_valid"}, out_valid, 1);
        if (out_valid) begin
            if (q.size() == 0) begin
                chk({name, "_unexpected"}, 1, 0);
            end else begin
                e = q.pop_front();
                chk({name, "_ch"}, out_ch, e.ch);
                chk({name, "_data"}, out_data, e.d);
                chk({name, "_last"}, out_last, e.l);
            end
        end
    endtask

    // Entered and left at posedge+1.
    task automatic rr_beat(input logic [3:0] valid, input int exp_ch);
        logic [3:0] one;
        one       = 4'b0001;
        in_valid  = valid;
        in_data   = D0;
        in_last   = '0;
        mode      = 1'b1;
        out_ready = 1'b1;
        q.push_back('{ch: 2'(exp_ch), d: byte_of(D0, exp_ch), l: 1'b0});
        #1 chk("rr_ready", in_ready, one << exp_ch);
        @(posedge clk); #1;
        pop_check("rr_out");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach summary, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    initial begin
        int b0, b1;
        logic [3:0] rdy;

        vecs[0] = '{4'b1111, D0, 4'b0000, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b0};
        vecs[1] = '{4'b1101, D0, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0};
        vecs[2] = '{4'b0001, D0, 4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1};
        vecs[3] = '{4'b0010, 32'h0000_1100, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b1, 8'h11,
                    2'd1, 1'b0};
        vecs[4] = '{4'b1111, D0, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1, 1'b0};
        vecs[5] = '{4'b1111, D0, 4'b0000, 1'b0, 2'd3, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1, 1'b0};
        vecs[6] = '{4'b0001, 32'h0000_0022, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'h22,
                    2'd0, 1'b0};

        // Reset with every channel requesting.
        rst_n = 1'b0; in_valid = 4'b1111; in_data = D0; in_last = '0;
        mode = 1'b1; sel = '0; out_ready = 1'b1;
        v5 = '0; d5 = '0; l5 = '0; sel5 = '0;
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("rst_in_ready_edge", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = '0;
        @(posedge clk); #1;
        chk("idle_out_valid", out_valid, 0);
        chk("idle_out_data", out_data, 0);
        chk("idle_out_ch", out_ch, 0);

        // Fixed select and backpressure vectors.
        for (int i = 0; i < 7; i++) begin
            in_valid = vecs[i].valid; in_data = vecs[i].data; in_last = vecs[i].last;
            mode = vecs[i].mode; sel = vecs[i].sel; out_ready = vecs[i].ordy;
            #1 chk($sformatf("vec%0d_ready", i), in_ready, vecs[i].exp_rdy);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_ov", i), out_valid, vecs[i].exp_ov);
            chk($sformatf("vec%0d_od", i), out_data, vecs[i].exp_od);
            chk($sformatf("vec%0d_ch", i), out_ch, vecs[i].exp_ch);
            chk($sformatf("vec%0d_ol", i), out_last, vecs[i].exp_ol);
        end

        // Round-robin fairness, then a sparse pair ending with the pointer at 2.
        for (int i = 0; i < 8; i++) rr_beat(4'b1111, i % 4);
        rr_beat(4'b1010, 1);
        rr_beat(4'b1010, 3);
        rr_beat(4'b1010, 1);
        rr_beat(4'b1010, 3);
        rr_beat(4'b1010, 1);
        chk("rr_sb_empty", q.size(), 0);

        // Asynchronous reset mid-cycle while holding a beat.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_ch", out_ch, 0);
        chk("arst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 4'b1111; mode = 1'b1; out_ready = 1'b1;
        #1 chk("arst_first_grant", in_ready, 4'b0001);
        @(posedge clk); #1;
        chk("arst_first_ch", out_ch, 0);
        chk("arst_first_valid", out_valid, 1);

        // Packet on ch0 (last on 3rd beat) against a continuously valid ch1.
        rst_n = 1'b0; in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
`ifdef STREAM_MUX_PKT_LOCK_EN
        q.push_back('{ch: 2'd0, d: 8'hC0, l: 1'b0});
        q.push_back('{ch: 2'd0, d: 8'hC1, l: 1'b0});
        q.push_back('{ch: 2'd0, d: 8'hC2, l: 1'b1});
        q.push_back('{ch: 2'd1, d: 8'hD0, l: 1'b1});
`else
        q.push_back('{ch: 2'd0, d: 8'hC0, l: 1'b0});
        q.push_back('{ch: 2'd1, d: 8'hD0, l: 1'b1});
        q.push_back('{ch: 2'd0, d: 8'hC1, l: 1'b0});
        q.push_back('{ch: 2'd1, d: 8'hD1, l: 1'b1});
`endif
        b0 = 0; b1 = 0;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            in_valid = {2'b00, b1 < 4, b0 < 3};
            in_data  = {16'h0, 8'(8'hD0 + b1), 8'(8'hC0 + b0)};
            in_last  = {2'b00, 1'b1, b0 == 2};
            mode = 1'b1; out_ready = 1'b1;
            #1 rdy = in_ready;
            @(posedge clk); #1;
            if (rdy[0]) b0++;
            if (rdy[1]) b1++;
            if (out_valid) pop_check("pkt");
        end
        chk("pkt_sb_empty", q.size(), 0);

        // Five channels: sel=4 is real, sel=5 and 7 are out of range.
        in_valid = '0; mode = 1'b0; out_ready = 1'b1;
        v5 = 5'b11111; d5 = 40'h55_44_33_22_11; l5 = '0; sel5 = 3'd4;
        #1 chk("n5_ready_sel4", r5, 5'b10000);
        @(posedge clk); #1;
        chk("n5_ov_sel4", ov5, 1);
        chk("n5_ch_sel4", och5, 4);
        chk("n5_od_sel4", od5, 8'h55);
        sel5 = 3'd5;
        #1 chk("n5_ready_sel5", r5, 0);
        @(posedge clk); #1;
        chk("n5_ov_sel5", ov5, 0);
        chk("n5_ch_hold", och5, 4);
        sel5 = 3'd7;
        #1 chk("n5_ready_sel7", r5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
